// File: rtl/image_switch_scheduler_if.sv
// ---------------------------------------------------------------------------
// image_switch_scheduler_if
// Request/response link between the image switch scheduler and the LCD
// display controller.
//   req_valid : scheduler -> display, a request is presented
//   req_id    : scheduler -> display, image ID, stable while req_valid=1
//   req_ready : display -> scheduler, request accepted when both are high
//   disp_done : display -> scheduler, single-cycle "frame fully drawn" pulse
// master = scheduler side, slave = display side.
// ---------------------------------------------------------------------------
interface image_switch_scheduler_if;
    logic       req_valid;
    logic [2:0] req_id;
    logic       req_ready;
    logic       disp_done;

    modport master (
        output req_valid,
        output req_id,
        input  req_ready,
        input  disp_done
    );

    modport slave (
        input  req_valid,
        input  req_id,
        output req_ready,
        output disp_done
    );
endinterface

// File: rtl/image_switch_scheduler.sv
// ---------------------------------------------------------------------------
// image_switch_scheduler
// Turns keypad pulses into image-change requests for the LCD controller.
// One request is in flight at a time; commands that arrive while a frame is
// being requested or drawn land in a single latest-wins pending slot.
// An optional slideshow generates "next" commands after a fixed dwell.
//
// Ports:
//   clk          25 MHz LCD clock
//   rst          synchronous active-high reset
//   key_pulse    16 single-cycle key press pulses (lowest index wins)
//   disp         master side of the display link (req_valid/req_id out,
//                req_ready/disp_done in)
//   cur_id       last successfully drawn image
//   pending      pending slot occupied
//   slideshow_on auto-advance enabled
//   drop_cnt     saturating count of overwritten pending commands
//   timeout_err  sticky flag: a draw did not complete in time
// ---------------------------------------------------------------------------
module image_switch_scheduler #(
    parameter int NUM_IMAGES     = 6,
    parameter int SLIDE_CYCLES   = 75000000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [15:0]                     key_pulse,
    image_switch_scheduler_if.master        disp,
    output logic [2:0]                      cur_id,
    output logic                            pending,
    output logic                            slideshow_on,
    output logic [7:0]                      drop_cnt,
    output logic                            timeout_err
);
    localparam int SW = ($clog2(SLIDE_CYCLES)   < 1) ? 1 : $clog2(SLIDE_CYCLES);
    localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0]    LAST_ID    = 3'(NUM_IMAGES - 1);
    localparam logic [3:0]    NUM_KEYS   = 4'(NUM_IMAGES);
    localparam logic [SW-1:0] SLIDE_LAST = SW'(SLIDE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAW} state_t;

    state_t        state_q, state_d;
    logic [2:0]    req_id_q, cur_id_q, pend_id_q;
    logic          pend_q, show_q, terr_q;
    logic [7:0]    drop_q;
    logic [SW-1:0] slide_q;
    logic [TW-1:0] to_q;

    logic [3:0]    key_idx;
    logic          key_any, key_img, key_tog, key_accept;
    logic [2:0]    base_id, next_id, prev_id, key_tgt, img_tgt;
    logic          slide_en, tick, img_cmd, handshake, to_expire;

    // Priority pick: scan downward so the lowest asserted index is kept.
    always_comb begin
        key_idx = 4'd0;
        key_any = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (key_pulse[i]) begin
                key_any = 1'b1;
                key_idx = 4'(i);
            end
        end
    end

    // Relative commands operate on the most recent target in the pipeline.
    always_comb begin
        if (pend_q)
            base_id = pend_id_q;
        else if (state_q != S_IDLE)
            base_id = req_id_q;
        else
            base_id = cur_id_q;
        // Compare-and-wrap keeps IDs inside 0..NUM_IMAGES-1 for any count.
        next_id = (base_id == LAST_ID) ? 3'd0 : base_id + 3'd1;
        prev_id = (base_id == 3'd0) ? LAST_ID : base_id - 3'd1;
    end

    always_comb begin
        key_img = 1'b0;
        key_tog = 1'b0;
        key_tgt = base_id;
        if (key_any) begin
            if (!key_idx[3]) begin
                if (key_idx < NUM_KEYS) begin
                    key_img = 1'b1;
                    key_tgt = key_idx[2:0];
                end
            end else begin
                case (key_idx[2:0])
                    3'd0: begin key_img = 1'b1; key_tgt = next_id; end
                    3'd1: begin key_img = 1'b1; key_tgt = prev_id; end
                    3'd2: key_tog = 1'b1;
                    3'd3: begin key_img = 1'b1; key_tgt = base_id; end
                    default: ;
                endcase
            end
        end
    end

    assign key_accept = key_img | key_tog;
    assign slide_en   = show_q && (state_q == S_IDLE) && !pend_q;
    // A real key in the same cycle swallows the slideshow tick.
    assign tick       = slide_en && (slide_q == SLIDE_LAST) && !key_accept;
    assign img_cmd    = key_img | tick;
    assign img_tgt    = key_img ? key_tgt : next_id;
    assign handshake  = (state_q == S_REQ) && disp.req_ready;
    assign to_expire  = (to_q == TO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (img_cmd || pend_q) state_d = S_REQ;
            S_REQ:  if (handshake) state_d = S_DRAW;
            S_DRAW: if (disp.disp_done || to_expire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        disp.req_valid = (state_q == S_REQ);
        disp.req_id    = req_id_q;
        cur_id         = cur_id_q;
        pending        = pend_q;
        slideshow_on   = show_q;
        drop_cnt       = drop_q;
        timeout_err    = terr_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_id_q  <= 3'd0;
            cur_id_q  <= 3'd0;
            pend_id_q <= 3'd0;
            pend_q    <= 1'b0;
            show_q    <= 1'b0;
            terr_q    <= 1'b0;
            drop_q    <= 8'd0;
            slide_q   <= '0;
            to_q      <= '0;
        end else begin
            if (key_accept || tick)
                slide_q <= '0;
            else if (slide_en)
                slide_q <= slide_q + SW'(1);

            // Counter only runs in DRAW, so it is already zero on entry.
            if (state_q != S_DRAW)
                to_q <= '0;
            else if (!to_expire)
                to_q <= to_q + TW'(1);

            if (key_tog)
                show_q <= ~show_q;

            // Any new command while the slot is full discards the old one.
            if (img_cmd && pend_q && (drop_q != 8'hFF))
                drop_q <= drop_q + 8'd1;

            if (state_q == S_IDLE) begin
                if (img_cmd) begin
                    req_id_q <= img_tgt;
                    pend_q   <= 1'b0;
                end else if (pend_q) begin
                    req_id_q <= pend_id_q;
                    pend_q   <= 1'b0;
                end
            end else if (img_cmd) begin
                pend_id_q <= img_tgt;
                pend_q    <= 1'b1;
            end

            if (state_q == S_DRAW) begin
                if (disp.disp_done)
                    cur_id_q <= req_id_q;
                else if (to_expire)
                    terr_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_image_switch_scheduler.sv
module tb_image_switch_scheduler;
    localparam int N = 6;
    localparam int S = 16;
    localparam int T = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key_pulse;
    logic [2:0]  cur_id;
    logic        pending, slideshow_on, timeout_err;
    logic [7:0]  drop_cnt;

    image_switch_scheduler_if dif();

    image_switch_scheduler #(
        .NUM_IMAGES(N), .SLIDE_CYCLES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst), .key_pulse(key_pulse), .disp(dif),
        .cur_id(cur_id), .pending(pending), .slideshow_on(slideshow_on),
        .drop_cnt(drop_cnt), .timeout_err(timeout_err)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0=idle, 1=requesting, 2=drawing
    int m_st, m_rid, m_cur, m_ptgt, m_drop, m_slide, m_to;
    bit m_pend, m_show, m_terr;

    // Display emulator
    int   done_timer = 0;
    int   done_delay = 0;
    bit   ready_rand = 0;
    bit   done_rand  = 0;
    logic ready_fix  = 1'b1;

    task automatic model_reset();
        m_st = 0; m_rid = 0; m_cur = 0; m_ptgt = 0; m_drop = 0;
        m_slide = 0; m_to = 0; m_pend = 0; m_show = 0; m_terr = 0;
    endtask

    task automatic model_step(input logic r, input logic [15:0] k,
                              input logic rdy, input logic dn);
        int idx, base, tgt, n_st, n_rid, n_cur, n_ptgt, n_drop, n_slide, n_to;
        bit acc, img, tog, tick, n_pend, n_show, n_terr;
        if (r) begin
            model_reset();
            return;
        end
        idx = -1;
        for (int i = 0; i < 16; i++)
            if (k[i] && idx < 0) idx = i;
        base = m_pend ? m_ptgt : ((m_st != 0) ? m_rid : m_cur);
        acc = 0; img = 0; tog = 0; tgt = 0;
        if (idx >= 0 && idx < 8) begin
            if (idx < N) begin acc = 1; img = 1; tgt = idx; end
        end else if (idx == 8) begin
            acc = 1; img = 1; tgt = (base + 1) % N;
        end else if (idx == 9) begin
            acc = 1; img = 1; tgt = (base + N - 1) % N;
        end else if (idx == 10) begin
            acc = 1; tog = 1;
        end else if (idx == 11) begin
            acc = 1; img = 1; tgt = base;
        end
        tick = m_show && m_st == 0 && !m_pend && m_slide == S - 1 && !acc;
        if (tick) begin img = 1; tgt = (base + 1) % N; end

        n_st = m_st; n_rid = m_rid; n_cur = m_cur; n_ptgt = m_ptgt;
        n_drop = m_drop; n_to = m_to; n_pend = m_pend; n_terr = m_terr;
        n_show = tog ? !m_show : m_show;
        if (acc || tick) n_slide = 0;
        else if (m_show && m_st == 0 && !m_pend) n_slide = m_slide + 1;
        else n_slide = m_slide;

        if (img && m_pend && m_drop < 255) n_drop = m_drop + 1;
        if (m_st == 0) begin
            if (img) begin n_rid = tgt; n_pend = 0; n_st = 1; end
            else if (m_pend) begin n_rid = m_ptgt; n_pend = 0; n_st = 1; end
        end else begin
            if (img) begin n_ptgt = tgt; n_pend = 1; end
            if (m_st == 1 && rdy) begin n_st = 2; n_to = 0; end
            if (m_st == 2) begin
                if (dn) begin n_cur = m_rid; n_st = 0; end
                else if (m_to == T - 1) begin n_st = 0; n_terr = 1; end
                else n_to = m_to + 1;
            end
        end
        m_st = n_st; m_rid = n_rid; m_cur = n_cur; m_ptgt = n_ptgt;
        m_drop = n_drop; m_to = n_to; m_pend = n_pend; m_terr = n_terr;
        m_show = n_show; m_slide = n_slide;
    endtask

    function automatic logic [17:0] model_vec();
        return {m_st == 1, 3'(m_rid), 3'(m_cur), m_pend, m_show, 8'(m_drop), m_terr};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {dif.req_valid, dif.req_id, cur_id, pending, slideshow_on, drop_cnt, timeout_err};
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare every output.
    task automatic cyc(input logic [15:0] k, input logic force_done);
        bit acc;
        key_pulse     = k;
        dif.req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
        dif.disp_done = force_done || (done_timer == 1) ||
                        (done_rand && $urandom_range(0, 29) == 0);
        @(posedge clk);
        acc = (m_st == 1) && dif.req_ready && !rst;
        model_step(rst, k, dif.req_ready, dif.disp_done);
        if (rst) done_timer = 0;
        else if (acc) done_timer = done_rand ? int'($urandom_range(1, 40)) : done_delay;
        else if (done_timer > 0) done_timer--;
        #1;
        $display("cyc keys=%04h rst=%0b rdy=%0b done=%0b -> valid=%0b id=%0d cur=%0d pend=%0b show=%0b drop=%0d terr=%0b",
                 k, rst, dif.req_ready, dif.disp_done, dif.req_valid, dif.req_id,
                 cur_id, pending, slideshow_on, drop_cnt, timeout_err);
        chk("cycle", dut_vec(), model_vec());
    endtask

    task automatic go(input logic [15:0] k);
        cyc(k, 1'b0);
        cyc(16'h0000, 1'b0);
        cyc(16'h0000, 1'b1);
    endtask

    initial begin
        int seen;
        logic [2:0] last;
        logic [15:0] k;
        rst = 1'b1; key_pulse = '0; dif.req_ready = 1'b0; dif.disp_done = 1'b0;
        model_reset();

        // Reset state
        cyc(16'h0000, 1'b0);
        rst = 1'b0;
        chk("rst_outputs", dut_vec(), 18'd0);

        // Select key 2, handshake, frame done
        cyc(16'h0004, 1'b0);
        chk("t1_valid", 18'(dif.req_valid), 18'd1);
        chk("t1_id", 18'(dif.req_id), 18'd2);
        cyc(16'h0000, 1'b0);
        chk("t1_accept", 18'(dif.req_valid), 18'd0);
        cyc(16'h0000, 1'b1);
        chk("t1_cur", 18'(cur_id), 18'd2);

        // Next/prev wrapping, out-of-range select
        go(16'h0020);
        chk("t2_cur5", 18'(cur_id), 18'd5);
        cyc(16'h0100, 1'b0);
        chk("t2_next_wrap", 18'(dif.req_id), 18'd0);
        cyc(16'h0000, 1'b0); cyc(16'h0000, 1'b1);
        cyc(16'h0200, 1'b0);
        chk("t2_prev_wrap", 18'(dif.req_id), 18'd5);
        cyc(16'h0000, 1'b0); cyc(16'h0000, 1'b1);
        cyc(16'h0080, 1'b0);
        chk("t2_key7_ignored", 18'(dif.req_valid), 18'd0);
        chk("t2_cur_kept", 18'(cur_id), 18'd5);

        // Pending overwrite during DRAW
        cyc(16'h0002, 1'b0); cyc(16'h0000, 1'b0);
        cyc(16'h0008, 1'b0); cyc(16'h0010, 1'b0);
        chk("t3_pending", 18'(pending), 18'd1);
        chk("t3_drop", 18'(drop_cnt), 18'd1);
        cyc(16'h0000, 1'b1);
        chk("t3_cur1", 18'(cur_id), 18'd1);
        chk("t3_not_yet", 18'(dif.req_valid), 18'd0);
        cyc(16'h0000, 1'b0);
        chk("t3_issue_valid", 18'(dif.req_valid), 18'd1);
        chk("t3_issue_id", 18'(dif.req_id), 18'd4);
        chk("t3_slot_clear", 18'(pending), 18'd0);
        cyc(16'h0000, 1'b0); cyc(16'h0000, 1'b1);

        // Multi-key priority
        cyc(16'h0A00, 1'b0);
        chk("t4_prev_wins", 18'(dif.req_id), 18'd3);
        cyc(16'h0000, 1'b0); cyc(16'h0000, 1'b1);
        cyc(16'h0401, 1'b0);
        chk("t4_key0_wins", 18'(dif.req_id), 18'd0);
        chk("t4_show_off", 18'(slideshow_on), 18'd0);
        cyc(16'h0000, 1'b0); cyc(16'h0000, 1'b1);

        // Slideshow advance and wrap
        done_delay = 3;
        cyc(16'h0400, 1'b0);
        chk("t5_show_on", 18'(slideshow_on), 18'd1);
        seen = 0;
        last = cur_id;
        for (int c = 0; c < 600 && seen < 6; c++) begin
            cyc(16'h0000, 1'b0);
            if (cur_id !== last) begin
                chk("t5_seq", 18'(cur_id), 18'((seen + 1) % N));
                seen++;
                last = cur_id;
            end
        end
        chk("t5_advances", 18'(seen), 18'd6);
        cyc(16'h0400, 1'b0);
        chk("t5_show_off", 18'(slideshow_on), 18'd0);
        repeat (60) cyc(16'h0000, 1'b0);
        chk("t5_stopped_cur", 18'(cur_id), 18'd0);
        chk("t5_stopped_valid", 18'(dif.req_valid), 18'd0);

        // Draw timeout
        done_delay = 0;
        cyc(16'h0008, 1'b0); cyc(16'h0000, 1'b0);
        repeat (31) cyc(16'h0000, 1'b0);
        chk("t6_no_err_yet", 18'(timeout_err), 18'd0);
        cyc(16'h0000, 1'b0);
        chk("t6_err", 18'(timeout_err), 18'd1);
        chk("t6_cur_kept", 18'(cur_id), 18'd0);
        cyc(16'h0020, 1'b0);
        chk("t6_idle_valid", 18'(dif.req_valid), 18'd1);
        chk("t6_idle_nopend", 18'(pending), 18'd0);
        chk("t6_idle_id", 18'(dif.req_id), 18'd5);

        // Reset while requesting
        rst = 1'b1;
        cyc(16'h0000, 1'b0);
        rst = 1'b0;
        chk("t7_rst_in_req", dut_vec(), 18'd0);

        // Randomized traffic against the model
        ready_rand = 1;
        done_rand  = 1;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) k = 16'h0000;
            else if (r < 9) k = 16'(1 << $urandom_range(0, 15));
            else k = 16'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            cyc(k, 1'b0);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
